// File: rtl/vram_port_arbiter.sv
// ============================================================================
//  Module  : vram_port_arbiter
//  Brief   : Shares VRAM port A between CPU (fixed priority) and blitter, with
//            a starvation guard and a tagged 2-stage read-return pipeline.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU bus interface
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  // GPU blitter
  input  logic        blt_req,
  input  logic        blt_we,
  input  logic [12:0] blt_addr,
  input  logic [15:0] blt_wdata,
  output logic        blt_gnt,
  output logic        blt_rvalid,
  output logic [15:0] blt_rdata,
  // BSRAM port A
  output logic        ram_cea,
  output logic        ram_wrea,
  output logic        ram_ocea,
  output logic        ram_reseta,
  output logic [12:0] ram_ada,
  output logic [15:0] ram_dina,
  input  logic [15:0] ram_douta
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0]  r_starve_cnt;
  logic        r_cea;
  logic        r_wrea;
  logic [12:0] r_ada;
  logic [15:0] r_dina;
  logic        r_s0_vld;
  logic        r_s0_own;
  logic        r_s1_vld;
  logic        r_s1_own;

  logic        w_force_blt;
  logic        w_cpu_gnt;
  logic        w_blt_gnt;
  logic        w_any_gnt;
  logic        w_win_we;
  logic [12:0] w_win_addr;
  logic [15:0] w_win_wdata;

  // Blitter is forced through once the CPU has won STARVE_MAX times in a row.
  assign w_force_blt = blt_req & (r_starve_cnt == c_STARVE_MAX);
  assign w_cpu_gnt   = cpu_req & ~w_force_blt & ~reset;
  assign w_blt_gnt   = blt_req & (~cpu_req | w_force_blt) & ~reset;
  assign w_any_gnt   = w_cpu_gnt | w_blt_gnt;

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = cpu_addr;
    w_win_wdata = cpu_wdata;
    if (w_blt_gnt) begin
      w_win_we    = blt_we;
      w_win_addr  = blt_addr;
      w_win_wdata = blt_wdata;
    end else if (w_cpu_gnt) begin
      w_win_we    = cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_blt_gnt || !blt_req) begin
      r_starve_cnt <= 4'd0;
    end else if (w_cpu_gnt) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cea  <= 1'b0;
      r_wrea <= 1'b0;
      r_ada  <= 13'd0;
      r_dina <= 16'd0;
    end else begin
      r_cea  <= w_any_gnt;
      r_wrea <= w_win_we;
      if (w_any_gnt) begin
        r_ada  <= w_win_addr;
        r_dina <= w_win_wdata;
      end
    end
  end

  // Owner bit: 1 = blitter. Stage 1 lines up with ram_douta of the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_vld <= 1'b0;
      r_s0_own <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_own <= 1'b0;
    end else begin
      r_s0_vld <= w_any_gnt & ~w_win_we;
      r_s0_own <= w_blt_gnt;
      r_s1_vld <= r_s0_vld;
      r_s1_own <= r_s0_own;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign blt_gnt    = w_blt_gnt;
  assign cpu_rvalid = r_s1_vld & ~r_s1_own;
  assign blt_rvalid = r_s1_vld & r_s1_own;
  assign cpu_rdata  = ram_douta;
  assign blt_rdata  = ram_douta;

  assign ram_cea    = r_cea;
  assign ram_wrea   = r_wrea;
  assign ram_ocea   = 1'b1;
  assign ram_reseta = reset;
  assign ram_ada    = r_ada;
  assign ram_dina   = r_dina;

endmodule

`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
// ============================================================================
//  Module  : tb_vram_port_arbiter
//  Brief   : Randomized self-checking bench for vram_port_arbiter with a
//            transaction-level reference model and a behavioural BSRAM.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, blt_req, blt_we;
  logic [12:0] cpu_addr, blt_addr;
  logic [15:0] cpu_wdata, blt_wdata;
  logic        cpu_gnt, cpu_rvalid, blt_gnt, blt_rvalid;
  logic [15:0] cpu_rdata, blt_rdata;
  logic        ram_cea, ram_wrea, ram_ocea, ram_reseta;
  logic [12:0] ram_ada;
  logic [15:0] ram_dina;
  logic [15:0] ram_douta;

  vram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid), .blt_rdata(blt_rdata),
    .ram_cea(ram_cea), .ram_wrea(ram_wrea), .ram_ocea(ram_ocea), .ram_reseta(ram_reseta),
    .ram_ada(ram_ada), .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  always #5 clk = ~clk;

  // Behavioural 8Kx16 BSRAM port A, bypass read: data one clock after command.
  logic [15:0] ram_mem [0:8191];
  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wrea) ram_mem[ram_ada] <= ram_dina;
      else          ram_douta        <= ram_mem[ram_ada];
    end
  end

  // Reference model state
  typedef struct {
    int          due;
    bit          blt;
    logic [15:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [15:0] gold [0:8191];
  int          cyc;
  int          starve;
  bit          e_cea, e_we;
  logic [12:0] e_ada;
  logic [15:0] e_dina;

  int n_vec;
  int n_err;

  // Pending commands held until granted
  bit          c_pend, c_we, b_pend, b_we;
  logic [12:0] c_addr, b_addr;
  logic [15:0] c_wd, b_wd;
  bit          last_gc, last_gb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [12:0] pick_addr();
    logic [12:0] hot [5];
    hot[0] = 13'h0000; hot[1] = 13'h0123; hot[2] = 13'h0FFF;
    hot[3] = 13'h1000; hot[4] = 13'h1FFF;
    if ($urandom_range(1, 0) == 1) return hot[$urandom_range(4, 0)];
    return 13'($urandom);
  endfunction

  // One clock: compare at negedge, advance model, then return 1 ns past posedge.
  task automatic step(output bit g_c, output bit g_b);
    bit          force_b, ec, eb, exp_cv, exp_bv;
    logic [15:0] exp_d;
    resp_t       r;
    @(negedge clk);
    force_b = blt_req && (starve == STARVE_MAX);
    ec = cpu_req && !force_b && !reset;
    eb = blt_req && (!cpu_req || force_b) && !reset;
    check_eq("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    check_eq("blt_gnt", 32'(blt_gnt), 32'(eb));

    exp_cv = 1'b0; exp_bv = 1'b0; exp_d = 16'h0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      if (r.blt) exp_bv = 1'b1; else exp_cv = 1'b1;
      exp_d = r.data;
    end
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
    check_eq("blt_rvalid", 32'(blt_rvalid), 32'(exp_bv));
    if (exp_cv) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
    if (exp_bv) check_eq("blt_rdata", 32'(blt_rdata), 32'(exp_d));
    check_eq("ram_cea", 32'(ram_cea), 32'(e_cea));
    check_eq("ram_wrea", 32'(ram_wrea), 32'(e_we));
    check_eq("ram_ada", 32'(ram_ada), 32'(e_ada));
    check_eq("ram_dina", 32'(ram_dina), 32'(e_dina));
    check_eq("ram_ocea", 32'(ram_ocea), 32'd1);
    check_eq("ram_reseta", 32'(ram_reseta), 32'(reset));

    if (reset) begin
      starve = 0;
      e_cea = 1'b0; e_we = 1'b0; e_ada = 13'h0; e_dina = 16'h0;
      resp_q.delete();
    end else begin
      e_cea = ec || eb;
      e_we  = 1'b0;
      if (ec) begin
        e_we = cpu_we; e_ada = cpu_addr; e_dina = cpu_wdata;
        if (cpu_we) gold[cpu_addr] = cpu_wdata;
        else resp_q.push_back('{due: cyc + 2, blt: 1'b0, data: gold[cpu_addr]});
      end
      if (eb) begin
        e_we = blt_we; e_ada = blt_addr; e_dina = blt_wdata;
        if (blt_we) gold[blt_addr] = blt_wdata;
        else resp_q.push_back('{due: cyc + 2, blt: 1'b1, data: gold[blt_addr]});
      end
      if (!blt_req || eb) starve = 0;
      else if (ec) starve++;
    end
    cyc++;
    g_c = ec;
    g_b = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    cpu_req = c_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    blt_req = b_pend; blt_we = b_we; blt_addr = b_addr; blt_wdata = b_wd;
    step(last_gc, last_gb);
    if (last_gc) c_pend = 1'b0;
    if (last_gb) b_pend = 1'b0;
  endtask

  task automatic cpu_cmd(input bit we, input logic [12:0] a, input logic [15:0] d);
    c_pend = 1'b1; c_we = we; c_addr = a; c_wd = d;
  endtask

  task automatic blt_cmd(input bit we, input logic [12:0] a, input logic [15:0] d);
    b_pend = 1'b1; b_we = we; b_addr = a; b_wd = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      gold[i]    = 16'((i * 40503) ^ 23130);
      ram_mem[i] = gold[i];
    end
    gold[0] = 16'h1111;    ram_mem[0] = 16'h1111;
    gold[8191] = 16'h2222; ram_mem[8191] = 16'h2222;
    ram_douta = 16'h0;
    n_vec = 0; n_err = 0; cyc = 0; starve = 0;
    e_cea = 1'b0; e_we = 1'b0; e_ada = 13'h0; e_dina = 16'h0;
    c_pend = 1'b0; c_we = 1'b0; c_addr = 13'h0; c_wd = 16'h0;
    b_pend = 1'b0; b_we = 1'b0; b_addr = 13'h0; b_wd = 16'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0; cpu_wdata = 16'h0;
    blt_req = 1'b0; blt_we = 1'b0; blt_addr = 13'h0; blt_wdata = 16'h0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle(1);                      // reset-state comparisons
    reset = 1'b0;
    idle(1);

    // CPU write then read-back in consecutive cycles
    cpu_cmd(1'b1, 13'h0123, 16'hBEEF); cycle();
    cpu_cmd(1'b0, 13'h0123, 16'h0);    cycle();
    idle(3);

    // Interleaved tagged reads
    cpu_cmd(1'b0, 13'h0000, 16'h0); cycle();
    blt_cmd(1'b0, 13'h1FFF, 16'h0); cycle();
    idle(3);

    // Starvation guard: both requesting every cycle
    for (int i = 0; i < 4 * (STARVE_MAX + 1); i++) begin
      cpu_cmd(1'($urandom), pick_addr(), 16'($urandom));
      blt_cmd(1'($urandom), pick_addr(), 16'($urandom));
      cycle();
      check_eq("starve_pattern", 32'(blt_gnt_seen()), 32'((i % (STARVE_MAX + 1)) == STARVE_MAX));
    end
    c_pend = 1'b0; b_pend = 1'b0;
    idle(3);

    // Blitter alone, then dropped while the CPU streams
    for (int i = 0; i < 6; i++) begin blt_cmd(1'b0, pick_addr(), 16'h0); cycle(); end
    for (int i = 0; i < 12; i++) begin
      cpu_cmd(1'b0, pick_addr(), 16'h0);
      if (i < 2 || i > 5) blt_cmd(1'b1, pick_addr(), 16'($urandom));
      else b_pend = 1'b0;
      cycle();
    end
    c_pend = 1'b0; b_pend = 1'b0;
    idle(3);

    // Reset one cycle after a CPU read grant
    cpu_cmd(1'b0, 13'h0123, 16'h0); cycle();
    cpu_cmd(1'b0, 13'h0000, 16'h0);
    blt_cmd(1'b0, 13'h1FFF, 16'h0);
    reset = 1'b1; idle(2);
    reset = 1'b0; idle(4);

    // Address extremes around the block boundary
    cpu_cmd(1'b1, 13'h0FFF, 16'hA5A5); cycle();
    cpu_cmd(1'b1, 13'h1000, 16'h5A5A); cycle();
    cpu_cmd(1'b0, 13'h0FFF, 16'h0);    cycle();
    blt_cmd(1'b0, 13'h1000, 16'h0);    cycle();
    idle(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (!c_pend && $urandom_range(99, 0) < 55) cpu_cmd(1'($urandom), pick_addr(), 16'($urandom));
      if (!b_pend && $urandom_range(99, 0) < 60) blt_cmd(1'($urandom), pick_addr(), 16'($urandom));
      reset = ($urandom_range(199, 0) == 0);
      cycle();
    end
    reset = 1'b0;
    c_pend = 1'b0; b_pend = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic bit blt_gnt_seen();
    return last_gb;
  endfunction

endmodule

`default_nettype wire
